// File: rtl/max10_adc_pkg.sv
// Shared definitions for the MAX10 ADC sampler stand-in.
//   CH_W / DATA_W : channel and sample widths of the Avalon-ST streams
//   CMD_W         : width of a stored command {channel, sop, eop}
//   adc_state_t   : converter FSM states
//   ramp_init()   : power-on/reset value of a channel's ramp ({ch, 7'b0})
package max10_adc_pkg;

    localparam int CH_W   = 5;
    localparam int DATA_W = 12;
    localparam int CMD_W  = CH_W + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        RESP = 2'd2
    } adc_state_t;

    function automatic logic [DATA_W-1:0] ramp_init(input logic [CH_W-1:0] ch);
        return {ch, 7'b0};
    endfunction

endpackage

// File: rtl/max10_adc_cmd_fifo.sv
// Small synchronous command FIFO for the ADC sampler (used only when
// MAX10_ADC_CMD_FIFO_EN is defined in the top level).
// Ports:
//   clk, rst_n  : clock and synchronous active-low reset (empties the FIFO)
//   push, push_data : write request and command word; ignored when full
//   pop         : remove the head entry; ignored when empty
//   head        : current head entry (first-word fall-through)
//   empty       : no entries stored
//   count       : number of stored entries (0..DEPTH)
module max10_adc_cmd_fifo
    import max10_adc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = CMD_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/max10_adc_sampler.sv
// Behavioural, synthesizable stand-in for the MAX10 on-chip ADC core.
// Accepts Avalon-ST conversion commands, waits CONV_CYCLES clocks and returns
// one 12-bit sample per command. Each channel 0..MAX_CHANNEL owns a ramp that
// starts at {ch, 7'b0} and advances by RAMP_STEP (mod 4096) per conversion;
// higher channels are accepted but always return 0.
// Optional feature macro: MAX10_ADC_CMD_FIFO_EN (4-entry command FIFO).
// Ports:
//   clock_clk, reset_sink_reset_n : clock, synchronous active-low reset
//   adc_pll_locked_export         : commands refused while low
//   command_*                     : command stream (valid/ready/channel/sop/eop)
//   response_*                    : result stream, one-cycle valid, no backpressure
module max10_adc_sampler
    import max10_adc_pkg::*;
#(
    parameter int                CONV_CYCLES = 20,
    parameter int                MAX_CHANNEL = 16,
    parameter logic [DATA_W-1:0] RAMP_STEP   = 12'd5
) (
    input  logic              clock_clk,
    input  logic              reset_sink_reset_n,
    input  logic              adc_pll_locked_export,
    input  logic              command_valid,
    input  logic [CH_W-1:0]   command_channel,
    input  logic              command_startofpacket,
    input  logic              command_endofpacket,
    output logic              command_ready,
    output logic              response_valid,
    output logic [CH_W-1:0]   response_channel,
    output logic [DATA_W-1:0] response_data,
    output logic              response_startofpacket,
    output logic              response_endofpacket
);

    localparam int                CNT_W    = (CONV_CYCLES > 2) ? $clog2(CONV_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(CONV_CYCLES - 1);
    localparam logic [CH_W-1:0]   MAX_CH   = CH_W'(MAX_CHANNEL);

    adc_state_t        state;
    adc_state_t        next_state;
    logic [CNT_W-1:0]  cnt;
    logic [CH_W-1:0]   cur_channel;
    logic              cur_sop;
    logic              cur_eop;
    logic [DATA_W-1:0] ramp [0:MAX_CHANNEL];

    logic              accept;
    logic              start;
    logic [CH_W-1:0]   src_channel;
    logic              src_sop;
    logic              src_eop;
    logic              resp_load;
    logic              ready_next;

    assign accept = command_valid && command_ready;

`ifdef MAX10_ADC_CMD_FIFO_EN
    logic             push;
    logic             pop;
    logic [CMD_W-1:0] fifo_head;
    logic             fifo_empty;
    logic [2:0]       fifo_count;
    logic [2:0]       count_next;
    logic [3:0]       occ_next;

    max10_adc_cmd_fifo #(
        .DEPTH (4),
        .WIDTH (CMD_W)
    ) u_cmd_fifo (
        .clk       (clock_clk),
        .rst_n     (reset_sink_reset_n),
        .push      (push),
        .push_data ({command_channel, command_startofpacket, command_endofpacket}),
        .pop       (pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Command source selection. An idle converter with an empty FIFO takes an
    // accepted command directly so the first result keeps the CONV_CYCLES
    // latency; otherwise the FIFO head is popped as soon as the converter is
    // free (IDLE, or the RESP cycle for back-to-back conversions).
    always_comb begin
        start       = 1'b0;
        push        = 1'b0;
        pop         = 1'b0;
        src_channel = command_channel;
        src_sop     = command_startofpacket;
        src_eop     = command_endofpacket;
        case (state)
            IDLE: begin
                if (fifo_empty) begin
                    start = accept;
                end else begin
                    start = 1'b1;
                    pop   = 1'b1;
                    push  = accept;
                    {src_channel, src_sop, src_eop} = fifo_head;
                end
            end
            RESP: begin
                push = accept;
                if (!fifo_empty) begin
                    start = 1'b1;
                    pop   = 1'b1;
                    {src_channel, src_sop, src_eop} = fifo_head;
                end
            end
            default: begin
                push = accept;
            end
        endcase
    end

    // Outstanding commands = stored entries + the one inside the converter.
    // Capping the total at four makes a fifth back-to-back command stall.
    always_comb begin
        count_next = fifo_count + 3'(push) - 3'(pop);
        occ_next   = 4'(count_next) + 4'(next_state != IDLE);
    end
`else
    // Single outstanding command: only an idle converter accepts.
    always_comb begin
        start       = (state == IDLE) && accept;
        src_channel = command_channel;
        src_sop     = command_startofpacket;
        src_eop     = command_endofpacket;
    end
`endif

    // State register.
    always_ff @(posedge clock_clk) begin
        if (!reset_sink_reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. RESP may chain straight into CONV when a queued
    // command is waiting (FIFO build only; start is never set in RESP otherwise).
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = CONV;
            CONV:    if (cnt == '0) next_state = RESP;
            RESP:    next_state = start ? CONV : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output logic. command_ready is registered from the next-state view so it
    // is already low in the cycle after an accept.
    always_comb begin
        response_valid = (state == RESP);
        resp_load      = (state == CONV) && (cnt == '0);
`ifdef MAX10_ADC_CMD_FIFO_EN
        ready_next     = adc_pll_locked_export && (occ_next < 4'd4);
`else
        ready_next     = adc_pll_locked_export && (next_state == IDLE);
`endif
    end

    // Datapath: conversion counter, latched command, result registers and the
    // per-channel ramps. Results are captured on the edge entering RESP, which
    // is also where the ramp advances, so the sample shown is the pre-step value.
    always_ff @(posedge clock_clk) begin
        if (!reset_sink_reset_n) begin
            command_ready          <= 1'b0;
            cnt                    <= '0;
            cur_channel            <= '0;
            cur_sop                <= 1'b0;
            cur_eop                <= 1'b0;
            response_channel       <= '0;
            response_data          <= '0;
            response_startofpacket <= 1'b0;
            response_endofpacket   <= 1'b0;
            for (int i = 0; i <= MAX_CHANNEL; i++) begin
                ramp[i] <= ramp_init(CH_W'(i));
            end
        end else begin
            command_ready <= ready_next;
            if (start) begin
                cnt         <= CNT_LOAD;
                cur_channel <= src_channel;
                cur_sop     <= src_sop;
                cur_eop     <= src_eop;
            end else if ((state == CONV) && (cnt != '0)) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (resp_load) begin
                response_channel       <= cur_channel;
                response_startofpacket <= cur_sop;
                response_endofpacket   <= cur_eop;
                if (cur_channel <= MAX_CH) begin
                    response_data     <= ramp[cur_channel];
                    ramp[cur_channel] <= ramp[cur_channel] + RAMP_STEP;
                end else begin
                    response_data <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_max10_adc_sampler.sv
// Self-checking bench for max10_adc_sampler: table of directed commands with
// hand-computed samples, plus sequences for lock loss, reset mid-conversion,
// 12-bit ramp wrap and (with MAX10_ADC_CMD_FIFO_EN) the command FIFO.
module tb_max10_adc_sampler;
    import max10_adc_pkg::*;

    logic              clock_clk = 1'b0;
    logic              reset_sink_reset_n;
    logic              adc_pll_locked_export;
    logic              command_valid;
    logic [CH_W-1:0]   command_channel;
    logic              command_startofpacket;
    logic              command_endofpacket;
    logic              command_ready;
    logic              response_valid;
    logic [CH_W-1:0]   response_channel;
    logic [DATA_W-1:0] response_data;
    logic              response_startofpacket;
    logic              response_endofpacket;

    int checks     = 0;
    int fails      = 0;
    int resp_count = 0;
    int cycle      = 0;

    typedef struct {
        logic [CH_W-1:0]   ch;
        logic              sop;
        logic              eop;
        logic [DATA_W-1:0] data;
    } vec_t;

    vec_t vecs [11];

    max10_adc_sampler dut (
        .clock_clk              (clock_clk),
        .reset_sink_reset_n     (reset_sink_reset_n),
        .adc_pll_locked_export  (adc_pll_locked_export),
        .command_valid          (command_valid),
        .command_channel        (command_channel),
        .command_startofpacket  (command_startofpacket),
        .command_endofpacket    (command_endofpacket),
        .command_ready          (command_ready),
        .response_valid         (response_valid),
        .response_channel       (response_channel),
        .response_data          (response_data),
        .response_startofpacket (response_startofpacket),
        .response_endofpacket   (response_endofpacket)
    );

    always #5 clock_clk = ~clock_clk;

    always @(posedge clock_clk) cycle++;

    always @(negedge clock_clk) begin
        if (response_valid === 1'b1) resp_count++;
    end

    task automatic check_val(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Present a command and wait (bounded) until the edge that accepts it.
    task automatic send_cmd(input logic [CH_W-1:0] ch, input logic sop, input logic eop,
                            input string name, output bit ok);
        int guard = 0;
        @(negedge clock_clk);
        command_valid         = 1'b1;
        command_channel       = ch;
        command_startofpacket = sop;
        command_endofpacket   = eop;
        while (command_ready !== 1'b1 && guard < 200) begin
            @(negedge clock_clk);
            guard++;
        end
        if (command_ready !== 1'b1) begin
            check_val({name, "_accept_timeout"}, 32'(command_ready), 32'd1);
            command_valid = 1'b0;
            ok = 1'b0;
        end else begin
            @(posedge clock_clk);
            #1 command_valid = 1'b0;
            ok = 1'b1;
        end
    endtask

    // Called just after the accept edge: count edges to response_valid and
    // note whether ready ever rose during the conversion.
    task automatic wait_response(output int latency, output bit seen, output bit ready_seen);
        latency    = 0;
        seen       = 1'b0;
        ready_seen = 1'b0;
        while (!seen && latency < 60) begin
            @(posedge clock_clk);
            #1;
            latency++;
            if (response_valid === 1'b1) seen = 1'b1;
            else if (command_ready !== 1'b0) ready_seen = 1'b1;
        end
    endtask

    task automatic check_output(input string name, input vec_t v, input int latency,
                                input bit seen, input bit ready_seen);
        check_val({name, "_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            check_val({name, "_latency"}, 32'(latency), 32'd20);
            check_val({name, "_ready_low"}, 32'(ready_seen), 32'd0);
            check_val({name, "_channel"}, 32'(response_channel), 32'(v.ch));
            check_val({name, "_data"}, 32'(response_data), 32'(v.data));
            check_val({name, "_sop"}, 32'(response_startofpacket), 32'(v.sop));
            check_val({name, "_eop"}, 32'(response_endofpacket), 32'(v.eop));
        end
    endtask

    task automatic apply_stimulus(input string name, input vec_t v);
        bit ok;
        int latency;
        bit seen;
        bit ready_seen;
        send_cmd(v.ch, v.sop, v.eop, name, ok);
        if (ok) begin
            wait_response(latency, seen, ready_seen);
            check_output(name, v, latency, seen, ready_seen);
        end
    endtask

    task automatic do_reset();
        @(negedge clock_clk);
        reset_sink_reset_n = 1'b0;
        repeat (2) @(negedge clock_clk);
        reset_sink_reset_n = 1'b1;
    endtask

    initial begin
        vec_t      v;
        bit        ok;
        int        base;
        bit        ready_seen;
        logic [DATA_W-1:0] model;

        vecs[0]  = '{ch: 5'd3,  sop: 1'b1, eop: 1'b1, data: 12'h180};
        vecs[1]  = '{ch: 5'd3,  sop: 1'b0, eop: 1'b0, data: 12'h185};
        vecs[2]  = '{ch: 5'd3,  sop: 1'b1, eop: 1'b0, data: 12'h18A};
        vecs[3]  = '{ch: 5'd0,  sop: 1'b0, eop: 1'b1, data: 12'h000};
        vecs[4]  = '{ch: 5'd16, sop: 1'b1, eop: 1'b1, data: 12'h800};
        vecs[5]  = '{ch: 5'd20, sop: 1'b1, eop: 1'b1, data: 12'h000};
        vecs[6]  = '{ch: 5'd31, sop: 1'b0, eop: 1'b0, data: 12'h000};
        vecs[7]  = '{ch: 5'd7,  sop: 1'b0, eop: 1'b1, data: 12'h380};
        vecs[8]  = '{ch: 5'd20, sop: 1'b0, eop: 1'b1, data: 12'h000};
        vecs[9]  = '{ch: 5'd16, sop: 1'b0, eop: 1'b0, data: 12'h805};
        vecs[10] = '{ch: 5'd17, sop: 1'b1, eop: 1'b0, data: 12'h000};

        reset_sink_reset_n    = 1'b0;
        adc_pll_locked_export = 1'b1;
        command_valid         = 1'b0;
        command_channel       = '0;
        command_startofpacket = 1'b0;
        command_endofpacket   = 1'b0;

        // Reset state.
        repeat (3) @(negedge clock_clk);
        check_val("reset_ready", 32'(command_ready), 32'd0);
        check_val("reset_valid", 32'(response_valid), 32'd0);
        check_val("reset_data", 32'(response_data), 32'd0);
        check_val("reset_channel", 32'(response_channel), 32'd0);
        reset_sink_reset_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            apply_stimulus($sformatf("vec%0d", i), vecs[i]);
        end

        // Lock lost: ready drops and a held command is ignored.
        $display("[TB] lock-loss sequence");
        @(negedge clock_clk);
        adc_pll_locked_export = 1'b0;
        @(negedge clock_clk);
        command_valid         = 1'b1;
        command_channel       = 5'd9;
        command_startofpacket = 1'b1;
        command_endofpacket   = 1'b0;
        base       = resp_count;
        ready_seen = 1'b0;
        repeat (6) begin
            @(negedge clock_clk);
            if (command_ready !== 1'b0) ready_seen = 1'b1;
        end
        check_val("unlocked_ready_low", 32'(ready_seen), 32'd0);
        check_val("unlocked_no_response", 32'(resp_count - base), 32'd0);
        adc_pll_locked_export = 1'b1;
        @(negedge clock_clk);
        check_val("relock_ready", 32'(command_ready), 32'd1);
        @(posedge clock_clk);
        #1 command_valid = 1'b0;
        begin
            int latency;
            bit seen;
            bit rs;
            wait_response(latency, seen, rs);
            v = '{ch: 5'd9, sop: 1'b1, eop: 1'b0, data: 12'h480};
            check_output("relock", v, latency, seen, rs);
        end

        // Reset in the middle of a conversion drops it and restores the ramps.
        $display("[TB] reset mid-conversion sequence");
        send_cmd(5'd5, 1'b1, 1'b1, "midreset", ok);
        repeat (10) @(posedge clock_clk);
        @(negedge clock_clk);
        reset_sink_reset_n = 1'b0;
        base = resp_count;
        @(negedge clock_clk);
        check_val("midreset_ready", 32'(command_ready), 32'd0);
        check_val("midreset_valid", 32'(response_valid), 32'd0);
        check_val("midreset_data", 32'(response_data), 32'd0);
        reset_sink_reset_n = 1'b1;
        repeat (30) @(negedge clock_clk);
        check_val("midreset_no_response", 32'(resp_count - base), 32'd0);
        apply_stimulus("post_reset_ch3", '{ch: 5'd3, sop: 1'b1, eop: 1'b1, data: 12'h180});
        apply_stimulus("post_reset_ch5", '{ch: 5'd5, sop: 1'b0, eop: 1'b0, data: 12'h280});
        apply_stimulus("post_reset_ch16", '{ch: 5'd16, sop: 1'b0, eop: 1'b1, data: 12'h800});

        // Drive channel 16 through the 12-bit wrap: ... FFD, 002.
        $display("[TB] ramp wrap sequence");
        model = 12'h805;
        for (int k = 0; k < 410; k++) begin
            apply_stimulus($sformatf("wrap%0d", k), '{ch: 5'd16, sop: 1'b0, eop: 1'b0, data: model});
            model = model + 12'd5;
        end

`ifdef MAX10_ADC_CMD_FIFO_EN
        // Four back-to-back commands fill the queue, the fifth stalls, and
        // results come out CONV_CYCLES+1 apart.
        $display("[TB] command FIFO sequence");
        do_reset();
        begin
            logic [CH_W-1:0]   fch  [4];
            logic [DATA_W-1:0] fdat [4];
            int                foff [4];
            int                t0 = 0;
            fch  = '{5'd1, 5'd2, 5'd4, 5'd6};
            fdat = '{12'h080, 12'h100, 12'h200, 12'h300};
            foff = '{20, 41, 62, 83};
            for (int k = 0; k < 4; k++) begin
                @(negedge clock_clk);
                check_val($sformatf("fifo_ready%0d", k), 32'(command_ready), 32'd1);
                command_valid         = 1'b1;
                command_channel       = fch[k];
                command_startofpacket = 1'b1;
                command_endofpacket   = 1'b1;
                @(posedge clock_clk);
                if (k == 0) begin
                    #1 t0 = cycle;
                end
            end
            @(negedge clock_clk);
            check_val("fifo_fifth_stalls", 32'(command_ready), 32'd0);
            command_valid = 1'b0;
            for (int r = 0; r < 4; r++) begin
                int guard = 0;
                do begin
                    @(posedge clock_clk);
                    #1 guard++;
                end while (response_valid !== 1'b1 && guard < 120);
                check_val($sformatf("fifo_resp%0d_offset", r), 32'(cycle - t0), 32'(foff[r]));
                check_val($sformatf("fifo_resp%0d_channel", r), 32'(response_channel), 32'(fch[r]));
                check_val($sformatf("fifo_resp%0d_data", r), 32'(response_data), 32'(fdat[r]));
            end
        end
`endif

        repeat (3) @(negedge clock_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
